// File: rtl/sprite_parse_pkg.sv
// rtl/sprite_parse_pkg.sv - shared types, attribute layout and width helpers for the sprite parser
package sprite_parse_pkg;

  typedef enum logic [2:0] {IDLE, REQ, EVAL, WRITE, DONE} parse_state_t;

  localparam int ATTR_W      = 16;
  localparam int SIZE_BITS   = 6;
  localparam int SIZE_ALWAYS = 32;

  // Y is MSB-aligned, CHAIN sits just below it, SIZE is LSB-aligned and
  // loses its upper bits when a wide Y leaves fewer than six bits free.
  function automatic int y_lsb(input int y_width);
    return ATTR_W - y_width;
  endfunction

  function automatic int chain_bit(input int y_width);
    return ATTR_W - 1 - y_width;
  endfunction

  function automatic int size_w(input int y_width);
    return (chain_bit(y_width) < SIZE_BITS) ? chain_bit(y_width) : SIZE_BITS;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sprite_parse_engine_if.sv
// rtl/sprite_parse_engine_if.sv - line control, VRAM attribute port and active-list display port
interface sprite_parse_engine_if
  import sprite_parse_pkg::*;
#(
  parameter int SPR_COUNT  = 381,
  parameter int ACTIVE_MAX = 96,
  parameter int Y_WIDTH    = 9,
  parameter int IDX_W      = $clog2(SPR_COUNT)
);
  localparam int AW    = $clog2(ACTIVE_MAX);
  localparam int CNT_W = count_width(ACTIVE_MAX);

  logic               NEW_LINE;
  logic [Y_WIDTH-1:0] RASTERC;
  logic               FLIP;
  logic               VRAM_REQ;
  logic [IDX_W-1:0]   VRAM_ADDR;
  logic               VRAM_ACK;
  logic [ATTR_W-1:0]  VRAM_DATA;
  logic [AW-1:0]      ACT_RD_ADDR;
  logic [IDX_W-1:0]   ACT_RD_DATA;
  logic [CNT_W-1:0]   ACT_COUNT;
  logic               ACT_FULL;
  logic               ACT_ABORT;
  logic               BUSY;

  modport master (
    input  NEW_LINE, RASTERC, FLIP, VRAM_ACK, VRAM_DATA, ACT_RD_ADDR,
    output VRAM_REQ, VRAM_ADDR, ACT_RD_DATA, ACT_COUNT, ACT_FULL, ACT_ABORT, BUSY
  );

  modport slave (
    output NEW_LINE, RASTERC, FLIP, VRAM_ACK, VRAM_DATA, ACT_RD_ADDR,
    input  VRAM_REQ, VRAM_ADDR, ACT_RD_DATA, ACT_COUNT, ACT_FULL, ACT_ABORT, BUSY
  );

endinterface

// File: rtl/active_list_bank.sv
// rtl/active_list_bank.sv - double-buffered active list, parser write port and registered display read port
module active_list_bank #(
  parameter int DEPTH = 96,
  parameter int WIDTH = 9,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/sprite_parse_engine.sv
// rtl/sprite_parse_engine.sv - per-line sprite Y parser building a double-buffered active list
module sprite_parse_engine
  import sprite_parse_pkg::*;
#(
  parameter int SPR_COUNT  = 381,
  parameter int FIRST_SPR  = 1,
  parameter int ACTIVE_MAX = 96,
  parameter int Y_WIDTH    = 9,
  parameter int LOOKAHEAD  = 2,
  parameter int IDX_W      = $clog2(SPR_COUNT)
) (
  input logic                   CLK_24M,
  input logic                   RESETP,
  sprite_parse_engine_if.master bus
);
  localparam int AW        = $clog2(ACTIVE_MAX);
  localparam int CNT_W     = count_width(ACTIVE_MAX);
  localparam int CHAIN_BIT = chain_bit(Y_WIDTH);
  localparam int SIZE_W    = size_w(Y_WIDTH);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_SPR);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SPR_COUNT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(ACTIVE_MAX);

  parse_state_t       state;
  logic [IDX_W-1:0]   idx;
  logic [ATTR_W-1:0]  attr_q;
  logic [Y_WIDTH-1:0] target;
  logic [CNT_W-1:0]   count;
  logic               full, chain_flag, bank_sel, vram_req, busy;
  logic [CNT_W-1:0]   act_count;
  logic               act_full, act_abort;

  logic [Y_WIDTH-1:0] attr_y, diff, tgt_sum;
  logic               attr_chain, raw_match, match, fill, last;
  logic [5:0]         attr_size;
  logic [CNT_W-1:0]   count_next;

  assign attr_y     = attr_q[ATTR_W-1 -: Y_WIDTH];
  assign attr_chain = attr_q[CHAIN_BIT];
  assign attr_size  = SIZE_BITS'(attr_q[SIZE_W-1:0]);
  assign diff       = target - attr_y;
  assign tgt_sum    = bus.RASTERC + Y_WIDTH'(LOOKAHEAD);
  assign count_next = count + 1'b1;
  assign fill       = (count_next == MAX_CNT);
  assign last       = (idx == LAST_IDX);

  always_comb begin
    raw_match = 1'b0;
    if (attr_size == '0)                    raw_match = 1'b0;
    else if (attr_size >= 6'(SIZE_ALWAYS))  raw_match = 1'b1;
    else raw_match = (16'(diff) < 16'({attr_size, 4'b0000}));
  end

  // A chained sprite inherits the verdict of the last unchained one.
  assign match = attr_chain ? chain_flag : raw_match;

  always_ff @(posedge CLK_24M or posedge RESETP) begin
    if (RESETP) begin
      state <= IDLE;       idx <= FIRST_IDX;    attr_q <= '0;     target <= '0;
      count <= '0;         full <= 1'b0;        chain_flag <= 1'b0;
      bank_sel <= 1'b0;    vram_req <= 1'b0;    busy <= 1'b0;
      act_count <= '0;     act_full <= 1'b0;    act_abort <= 1'b0;
    end else if (bus.NEW_LINE) begin
      bank_sel <= ~bank_sel;
      // A WRITE in flight lands in the old bank on this same edge, so report it.
      if (state == WRITE) begin
        act_count <= count_next;
        act_full  <= fill;
        act_abort <= !(fill || last);
      end else begin
        act_count <= count;
        act_full  <= full;
        act_abort <= (state == REQ) || (state == EVAL);
      end
      count <= '0;  full <= 1'b0;  chain_flag <= 1'b0;
      target   <= bus.FLIP ? ~tgt_sum : tgt_sum;
      idx      <= FIRST_IDX;
      vram_req <= 1'b1;
      busy     <= 1'b1;
      state    <= REQ;
    end else begin
      case (state)
        REQ: if (bus.VRAM_ACK) begin
          attr_q   <= bus.VRAM_DATA;
          vram_req <= 1'b0;
          state    <= EVAL;
        end
        EVAL: begin
          if (!attr_chain) chain_flag <= raw_match;
          if (match)     state <= WRITE;
          else if (last) begin state <= DONE; busy <= 1'b0; end
          else           begin idx <= idx + 1'b1; vram_req <= 1'b1; state <= REQ; end
        end
        WRITE: begin
          count <= count_next;
          if (fill)      begin full <= 1'b1; state <= DONE; busy <= 1'b0; end
          else if (last) begin state <= DONE; busy <= 1'b0; end
          else           begin idx <= idx + 1'b1; vram_req <= 1'b1; state <= REQ; end
        end
        default: ;
      endcase
    end
  end

  active_list_bank #(.DEPTH(ACTIVE_MAX), .WIDTH(IDX_W), .AW(AW)) u_bank (
    .clk     (CLK_24M),
    .rst     (RESETP),
    .we      (state == WRITE),
    .wr_bank (bank_sel),
    .wr_addr (AW'(count)),
    .wr_data (idx),
    .rd_bank (~bank_sel),
    .rd_addr (bus.ACT_RD_ADDR),
    .rd_data (bus.ACT_RD_DATA)
  );

  assign bus.VRAM_REQ  = vram_req;
  assign bus.VRAM_ADDR = idx;
  assign bus.ACT_COUNT = act_count;
  assign bus.ACT_FULL  = act_full;
  assign bus.ACT_ABORT = act_abort;
  assign bus.BUSY      = busy;

endmodule

// File: tb/tb_sprite_parse_engine.sv
// tb/tb_sprite_parse_engine.sv - self-checking bench for sprite_parse_engine
module tb_sprite_parse_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_parse_engine_if #(.SPR_COUNT(381), .ACTIVE_MAX(96), .Y_WIDTH(9))  bus_a ();
  sprite_parse_engine_if #(.SPR_COUNT(16),  .ACTIVE_MAX(96), .Y_WIDTH(10)) bus_b ();

  sprite_parse_engine #(.SPR_COUNT(381), .ACTIVE_MAX(96), .Y_WIDTH(9))  dut_a (.CLK_24M(clk), .RESETP(rst), .bus(bus_a));
  sprite_parse_engine #(.SPR_COUNT(16),  .ACTIVE_MAX(96), .Y_WIDTH(10)) dut_b (.CLK_24M(clk), .RESETP(rst), .bus(bus_b));

  logic [15:0] attr_a [381];
  logic [15:0] attr_b [16];
  int delay_a = 0;
  int max_addr_a = 0;
  int ack_cnt_a = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  typedef struct {
    int rasterc;
    bit flip;
    int exp_count;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus_a.VRAM_ACK = 1'b0;
    bus_a.VRAM_DATA = '0;
    forever begin
      @(posedge clk); #1;
      bus_a.VRAM_ACK = 1'b0;
      bus_a.VRAM_DATA = '0;
      if (bus_a.VRAM_REQ) begin
        if (wait_cnt >= delay_a) begin
          bus_a.VRAM_ACK = 1'b1;
          bus_a.VRAM_DATA = attr_a[bus_a.VRAM_ADDR];
          wait_cnt = 0;
          ack_cnt_a++;
          if (int'(bus_a.VRAM_ADDR) > max_addr_a) max_addr_a = int'(bus_a.VRAM_ADDR);
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  initial begin
    bus_b.VRAM_ACK = 1'b0;
    bus_b.VRAM_DATA = '0;
    forever begin
      @(posedge clk); #1;
      bus_b.VRAM_ACK = bus_b.VRAM_REQ;
      bus_b.VRAM_DATA = bus_b.VRAM_REQ ? attr_b[bus_b.VRAM_ADDR] : 16'h0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0] tgt_a(input int r, input bit f);
    logic [8:0] t;
    t = 9'(r + 2);
    return f ? ~t : t;
  endfunction

  // Reference scan over attr_a: pushes expected entries, returns their count.
  function automatic int model_a(input logic [8:0] tgt, input int last_idx);
    int n, s, d;
    bit chain, raw, m;
    logic [15:0] w;
    logic [8:0] y;
    n = 0;
    chain = 1'b0;
    for (int i = 1; i <= last_idx; i++) begin
      w = attr_a[i];
      y = w[15:7];
      s = int'(w[5:0]);
      d = int'(9'(tgt - y));
      if (s == 0) raw = 1'b0;
      else if (s >= 32) raw = 1'b1;
      else raw = (d < s * 16);
      if (w[6]) m = chain;
      else begin m = raw; chain = raw; end
      if (m) begin
        exp_q.push_back(i);
        n++;
        if (n == 96) break;
      end
    end
    return n;
  endfunction

  task automatic nl_a(input int r, input bit f);
    bus_a.RASTERC = 9'(r);
    bus_a.FLIP = f;
    bus_a.NEW_LINE = 1'b1;
    max_addr_a = 0;
    ack_cnt_a = 0;
    @(posedge clk); #1;
    bus_a.NEW_LINE = 1'b0;
  endtask

  task automatic wait_done_a();
    int k;
    k = 0;
    while (bus_a.BUSY && k < 5000) begin @(posedge clk); #1; k++; end
    chk("parse_done_a", bus_a.BUSY, 0);
  endtask

  task automatic check_list_a(input string tag, input int n);
    int e;
    for (int i = 0; i < n; i++) begin
      bus_a.ACT_RD_ADDR = 7'(i);
      @(posedge clk); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk($sformatf("%s_entry%0d", tag, i), bus_a.ACT_RD_DATA, e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},     bus_a.VRAM_REQ, 0);
    chk({tag, "_addr"},    bus_a.VRAM_ADDR, 1);
    chk({tag, "_count"},   bus_a.ACT_COUNT, 0);
    chk({tag, "_full"},    bus_a.ACT_FULL, 0);
    chk({tag, "_abort"},   bus_a.ACT_ABORT, 0);
    chk({tag, "_busy"},    bus_a.BUSY, 0);
    chk({tag, "_rd_data"}, bus_a.ACT_RD_DATA, 0);
  endtask

  initial begin
    int k;
    vecs[0] = '{10,  1'b0, 4};
    vecs[1] = '{18,  1'b0, 4};
    vecs[2] = '{38,  1'b0, 0};
    vecs[3] = '{27,  1'b0, 3};
    vecs[4] = '{510, 1'b0, 3};
    vecs[5] = '{495, 1'b1, 4};

    bus_a.NEW_LINE = 1'b0; bus_a.RASTERC = '0; bus_a.FLIP = 1'b0; bus_a.ACT_RD_ADDR = '0;
    bus_b.NEW_LINE = 1'b0; bus_b.RASTERC = '0; bus_b.FLIP = 1'b0; bus_b.ACT_RD_ADDR = '0;
    for (int i = 0; i < 381; i++) attr_a[i] = 16'h0;
    for (int i = 0; i < 16; i++)  attr_b[i] = 16'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("req_before_new_line", bus_a.VRAM_REQ, 0);

    // sprite 5 Y=12 SIZE=1; sprite 7 Y=0 SIZE=2 heads a chain through 8 and 9
    attr_a[5] = {9'd12, 1'b0, 6'd1};
    attr_a[7] = {9'd0,  1'b0, 6'd2};
    attr_a[8] = 16'h0040;
    attr_a[9] = 16'h0040;

    for (int i = 0; i < 6; i++) begin
      nl_a(vecs[i].rasterc, vecs[i].flip);
      if (i > 0) begin
        chk($sformatf("vec%0d_count", i - 1), bus_a.ACT_COUNT, vecs[i-1].exp_count);
        chk($sformatf("vec%0d_full", i - 1),  bus_a.ACT_FULL, 0);
        chk($sformatf("vec%0d_abort", i - 1), bus_a.ACT_ABORT, 0);
        check_list_a($sformatf("vec%0d", i - 1), vecs[i-1].exp_count);
      end
      void'(model_a(tgt_a(vecs[i].rasterc, vecs[i].flip), 380));
      wait_done_a();
    end

    for (int i = 1; i <= 100; i++) attr_a[i] = 16'h0020;
    nl_a(0, 1'b0);
    chk("vec5_count", bus_a.ACT_COUNT, vecs[5].exp_count);
    check_list_a("vec5", vecs[5].exp_count);
    void'(model_a(tgt_a(0, 1'b0), 380));
    wait_done_a();
    chk("full_max_req_addr", max_addr_a, 96);

    // NEW_LINE lands on the WRITE of the 96th entry (3 cycles per matching sprite)
    nl_a(0, 1'b0);
    fork
      begin
        repeat (287) @(posedge clk);
        #1;
        bus_a.NEW_LINE = 1'b1;
        @(posedge clk); #1;
        bus_a.NEW_LINE = 1'b0;
      end
      begin
        chk("full_count", bus_a.ACT_COUNT, 96);
        chk("full_flag",  bus_a.ACT_FULL, 1);
        chk("full_abort", bus_a.ACT_ABORT, 0);
        check_list_a("full", 96);
      end
    join
    chk("coincide_count", bus_a.ACT_COUNT, 96);
    chk("coincide_full",  bus_a.ACT_FULL, 1);
    chk("coincide_abort", bus_a.ACT_ABORT, 0);
    wait_done_a();

    for (int i = 0; i < 381; i++) attr_a[i] = 16'h0;
    attr_a[2] = 16'h0020; attr_a[4] = 16'h0020; attr_a[6] = 16'h0020; attr_a[12] = 16'h0020;
    delay_a = 5;
    nl_a(0, 1'b0);
    void'(model_a(tgt_a(0, 1'b0), 10));
    k = 0;
    while (ack_cnt_a < 10 && k < 1000) begin @(posedge clk); #1; k++; end
    chk("abort_ten_acks", ack_cnt_a >= 10, 1);
    repeat (2) @(posedge clk);
    #1;
    nl_a(5, 1'b0);
    chk("abort_flag",    bus_a.ACT_ABORT, 1);
    chk("abort_count",   bus_a.ACT_COUNT, 3);
    chk("abort_full",    bus_a.ACT_FULL, 0);
    chk("restart_req",   bus_a.VRAM_REQ, 1);
    chk("restart_addr",  bus_a.VRAM_ADDR, 1);
    check_list_a("abort", 3);
    delay_a = 0;
    wait_done_a();

    nl_a(0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    nl_a(0, 1'b0);
    chk("post_reset_req",  bus_a.VRAM_REQ, 1);
    chk("post_reset_addr", bus_a.VRAM_ADDR, 1);
    chk("post_reset_busy", bus_a.BUSY, 1);
    wait_done_a();

    // Y_WIDTH=10: Y=1020 SIZE=1 against target 2 matches across the wrap
    attr_b[3] = 16'hFF01;
    for (int pass = 0; pass < 2; pass++) begin
      bus_b.RASTERC = '0;
      bus_b.NEW_LINE = 1'b1;
      @(posedge clk); #1;
      bus_b.NEW_LINE = 1'b0;
      if (pass == 0) begin
        k = 0;
        while (bus_b.BUSY && k < 500) begin @(posedge clk); #1; k++; end
        chk("wrap_parse_done", bus_b.BUSY, 0);
      end
    end
    chk("wrap_count", bus_b.ACT_COUNT, 1);
    chk("wrap_full",  bus_b.ACT_FULL, 0);
    chk("wrap_abort", bus_b.ACT_ABORT, 0);
    bus_b.ACT_RD_ADDR = '0;
    @(posedge clk); #1;
    chk("wrap_entry0", bus_b.ACT_RD_DATA, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_parse_engine.md
# sprite_parse_engine

Parametrised successor to the fast-cycle Y parser and active-list builder. Each line it scans the sprite attribute table through a request/acknowledge VRAM port, tests every sprite's Y span against a look-ahead raster line, applies sticky-chain inheritance, and appends matching indices to one bank of a double-buffered active list. The renderer reads the other bank. Sprite count, list depth and Y width are generic, so the same block serves the stock 381/96 configuration and extended variants.

## Interface
- SPR_COUNT, 381: number of sprite slots scanned; indices FIRST_SPR..SPR_COUNT-1
- FIRST_SPR, 1: first scanned index; slot 0 is never parsed
- ACTIVE_MAX, 96: active-list depth per bank
- Y_WIDTH, 9: Y coordinate and raster width
- LOOKAHEAD, 2: lines added to RASTERC to form the target line
- IDX_W, $clog2(SPR_COUNT): sprite index width
- CLK_24M  in  1  sole clock; all state is on the rising edge
- RESETP  in  1  asynchronous, active-high reset
- NEW_LINE  in  1  one-cycle strobe marking the start of a line
- RASTERC  in  Y_WIDTH  current raster line, sampled on NEW_LINE
- FLIP  in  1  vertical flip, sampled on NEW_LINE
- VRAM_REQ  out  1  attribute read request
- VRAM_ADDR  out  IDX_W  sprite index being read
- VRAM_ACK  in  1  one-cycle pulse; VRAM_DATA is valid in the same cycle
- VRAM_DATA  in  16  {Y[Y_WIDTH-1:0], CHAIN, SIZE[5:0]}, MSB-aligned, unused bits zero
- ACT_RD_ADDR  in  $clog2(ACTIVE_MAX)  renderer read index into the display bank
- ACT_RD_DATA  out  IDX_W  registered entry, 1-cycle latency
- ACT_COUNT  out  $clog2(ACTIVE_MAX+1)  number of valid entries in the display bank
- ACT_FULL  out  1  display bank reached ACTIVE_MAX
- ACT_ABORT  out  1  display bank parse was cut short by NEW_LINE
- BUSY  out  1  parse in progress

## Operation
- FSM states: IDLE, REQ, EVAL, WRITE, DONE. Reset enters IDLE with index FIRST_SPR.
- NEW_LINE, any state:
  - swap the write and display banks
  - latch the finished count, full and abort flags into the ACT_* outputs
  - clear the write count and the chain flag
  - target = (RASTERC + LOOKAHEAD) mod 2^Y_WIDTH; when FLIP is set, target = ~target
  - go to REQ at FIRST_SPR
- REQ: assert VRAM_REQ with VRAM_ADDR = index and hold both until VRAM_ACK. On VRAM_ACK, register the data and go to EVAL.
- EVAL:
  - raw match: SIZE == 0 never matches; SIZE ≥ 32 always matches; otherwise match when (target − Y) mod 2^Y_WIDTH < SIZE×16
  - with CHAIN=0: match = raw match, and the chain flag is set to match
  - with CHAIN=1: match = chain flag; the chain flag is unchanged
  - on match go to WRITE; otherwise advance
- WRITE: store index at write_bank[count], increment count. When count reaches ACTIVE_MAX, set full and go to DONE; otherwise advance.
- Advance: increment index. When index reaches SPR_COUNT go to DONE; otherwise go to REQ.
- DONE: idle until NEW_LINE. BUSY = state ∉ {IDLE, DONE}.
- An aborted line (NEW_LINE before DONE) keeps the entries written so far. ACT_ABORT=1 for that bank.

## Timing
- Reset values:
  - VRAM_REQ=0, VRAM_ADDR=FIRST_SPR
  - ACT_COUNT=0, ACT_FULL=0, ACT_ABORT=0, BUSY=0, ACT_RD_DATA=0
  - bank select=0
  - list RAM contents are undefined
- NEW_LINE to first VRAM_REQ: 1 cycle.
- Per sprite, from VRAM_ACK: 1 cycle for a miss, 2 cycles for a match.
- ACT_* outputs change on the cycle after NEW_LINE and are stable for the whole line.
- NEW_LINE coincident with VRAM_ACK: the ACK is discarded and the restart wins.
- NEW_LINE coincident with the WRITE that fills the list: the write completes into the old bank first, so that bank reports ACT_FULL=1 and ACT_ABORT=0.
- RESETP asserted mid-parse: immediate return to reset values; the next NEW_LINE starts cleanly.

## Structure
- Package sprite_parse_pkg holds:
  - the state enum
  - attribute field offsets within VRAM_DATA
  - the SIZE_ALWAYS=32 constant
  - a function computing the width of a count
- Sub-module active_list_bank: two ACTIVE_MAX×IDX_W banks with one write port (parser side) and one registered read port (display side), selected by the bank bit.

## Test plan
- Reset with RESETP high for 3 cycles -> all outputs at reset values; VRAM_REQ stays low until NEW_LINE.
- RASTERC=10, sprite 5 Y=12 SIZE=1, NEW_LINE -> sprite 5 matches (target 12), ACT_COUNT=1 next line, ACT_RD_ADDR=0 returns 5.
- Sprite 7 SIZE=2 Y=0, sprites 8 and 9 CHAIN=1, target 20 -> entries 7, 8, 9; the same chain with target 40 -> no entries.
- 100 sprites all SIZE=32 (ACTIVE_MAX=96) -> ACT_COUNT=96, ACT_FULL=1, sprite 97 never requested.
- ACK delayed 5 cycles per read, NEW_LINE after 10 sprites -> ACT_ABORT=1, ACT_COUNT equals the matches among those 10, and the new scan restarts at index 1.
- SPR_COUNT=16, Y_WIDTH=10, Y=1020 SIZE=1, target 2 -> match across the wrap (difference 6), ACT_COUNT=1.
